// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus initiator: command opcodes, FSM states
// and counter sizing helpers.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    EVAL,
    GAP,
    RESP
  } state_e;

  // Number of bits needed to hold the value 'value' (at least one).
  function automatic int bits_for(input int value);
    int w;
    w = 1;
    while ((1 << w) <= value) w++;
    return w;
  endfunction

  // The reserved encoding behaves as a plain read.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'b00:   return OP_WR;
      2'b10:   return OP_POLL;
      default: return OP_RD;
    endcase
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns write/read/poll commands into CSB/WRB/CA/CD_wr
// cycles, captures read data and returns one response per command.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 1,
  parameter int POLL_MAX   = 16,
  parameter int POLL_GAP   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [15:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout,
  output logic        CSB,
  output logic        WRB,
  output logic [7:0]  CA,
  output logic [15:0] CD_wr,
  input  logic [15:0] CD_rd,
  output logic        busy
);

  localparam int PH_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int PH_B   = (HOLD_CYC > POLL_GAP) ? HOLD_CYC : POLL_GAP;
  localparam int PH_MAX = (PH_A > PH_B) ? PH_A : PH_B;
  localparam int PH_W   = bits_for(PH_MAX);
  localparam int PC_W   = bits_for(POLL_MAX);

  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYC - 1);
  localparam logic [PH_W-1:0] HOLD_LD   = PH_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [PH_W-1:0] GAP_LD    = PH_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [PC_W-1:0] POLL_LIM  = PC_W'(POLL_MAX);

  state_e            state;
  state_e            state_next;
  logic [PH_W-1:0]   phase_cnt;
  logic [PH_W-1:0]   load_val;
  logic [PC_W-1:0]   poll_cnt;
  op_e               op_q;
  logic [15:0]       data_q;
  logic [15:0]       mask_q;
  logic [15:0]       rd_q;
  logic              cmd_fire;
  logic              last_phase;
  logic              poll_match;
  logic              poll_exhausted;
  logic              read_edge;

  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign rsp_valid      = (state == RESP);
  assign cmd_fire       = cmd_valid && cmd_ready;
  assign last_phase     = (phase_cnt == '0);
  assign poll_match     = (((rd_q ^ data_q) & mask_q) == '0);
  assign poll_exhausted = (poll_cnt == POLL_LIM);
  assign read_edge      = (state == STROBE) && last_phase && (op_q != OP_WR);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (cmd_valid) state_next = SETUP;
      SETUP:  if (last_phase) state_next = STROBE;
      STROBE: if (last_phase) state_next = (HOLD_CYC > 0) ? HOLD : EVAL;
      HOLD:   if (last_phase) state_next = EVAL;
      EVAL: begin
        if (op_q != OP_POLL || poll_match || poll_exhausted) state_next = RESP;
        else state_next = (POLL_GAP > 0) ? GAP : SETUP;
      end
      GAP:    if (last_phase) state_next = SETUP;
      RESP:   if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every timed phase reloads the shared counter on entry and leaves at zero.
  always_comb begin
    load_val = '0;
    case (state_next)
      SETUP:   load_val = SETUP_LD;
      STROBE:  load_val = STROBE_LD;
      HOLD:    load_val = HOLD_LD;
      GAP:     load_val = GAP_LD;
      default: load_val = '0;
    endcase
  end

  // Control: state, phase/poll counters and the bus strobes, registered from next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      poll_cnt  <= '0;
      CSB       <= 1'b1;
      WRB       <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next != state) phase_cnt <= load_val;
      else if (!last_phase) phase_cnt <= phase_cnt - PH_W'(1);
      if (cmd_fire) poll_cnt <= '0;
      else if (read_edge && !poll_exhausted) poll_cnt <= poll_cnt + PC_W'(1);
      CSB <= (state_next != STROBE);
      WRB <= !((state_next == STROBE) && (op_q == OP_WR));
    end
  end

  // Datapath: command latch, bus address/data, read capture and response.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q        <= OP_RD;
      data_q      <= '0;
      mask_q      <= '0;
      rd_q        <= '0;
      CA          <= '0;
      CD_wr       <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_q   <= decode_op(cmd_op);
        data_q <= cmd_data;
        mask_q <= cmd_mask;
        CA     <= cmd_addr;
        CD_wr  <= (decode_op(cmd_op) == OP_WR) ? cmd_data : '0;
      end
      if (read_edge) rd_q <= CD_rd;
      if (state == EVAL) begin
        rsp_data    <= (op_q == OP_WR) ? data_q : rd_q;
        rsp_timeout <= (op_q == OP_POLL) && !poll_match && poll_exhausted;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: directed vector table, poll/backpressure/reset sequences
// and random commands against a register-file slave and a reference memory model.
module tb_reg_bus_master;

  localparam int POLL_MAX = 4;
  localparam logic [1:0] OPW = 2'b00, OPR = 2'b01, OPP = 2'b10, OPX = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data, cmd_mask;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_timeout;
  logic        CSB, WRB;
  logic [7:0]  CA;
  logic [15:0] CD_wr, CD_rd;
  logic        busy;

  reg_bus_master #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .POLL_MAX(POLL_MAX), .POLL_GAP(2)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .CSB(CSB), .WRB(WRB), .CA(CA), .CD_wr(CD_wr), .CD_rd(CD_rd), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Register-file slave: 128 x 16, index CA[7:1]; reg 0x22 (byte 0x44) resets to 4,
  // reg 0x1E (byte 0x3C) is a grant status driven by the bench.
  logic [15:0] slave_mem [128];
  logic        slave_clr;
  int unsigned grant_base = 0, grant_after = 1000;

  always @(posedge Clk) begin
    if (slave_clr) begin
      for (int i = 0; i < 128; i++) slave_mem[i] <= (i == 'h22) ? 16'h0004 : 16'h0000;
    end else if (!CSB && !WRB) begin
      slave_mem[CA[7:1]] <= CD_wr;
    end
  end

  int unsigned rd_strobes = 0, wr_strobes = 0, strobe_starts = 0, cyc = 0, bus_glitch = 0;
  int unsigned start_at [64];
  logic [7:0]  wr_ca = '0, prev_ca = '0;
  logic [15:0] wr_cd = '0, prev_cd = '0;
  logic        prev_csb = 1'b1;

  always_comb begin
    if (CA[7:1] == 7'h1E) CD_rd = {15'd0, ((rd_strobes - grant_base) >= grant_after)};
    else CD_rd = slave_mem[CA[7:1]];
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (!CSB) begin
      if (WRB) rd_strobes <= rd_strobes + 1;
      else begin
        wr_strobes <= wr_strobes + 1;
        wr_ca <= CA;
        wr_cd <= CD_wr;
      end
      if (prev_csb) begin
        start_at[strobe_starts % 64] <= cyc;
        strobe_starts <= strobe_starts + 1;
      end else if (CA != prev_ca || CD_wr != prev_cd) begin
        bus_glitch <= bus_glitch + 1;
      end
    end
    prev_csb <= CSB;
    prev_ca  <= CA;
    prev_cd  <= CD_wr;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data,
                        input logic [15:0] mask, input int ready_delay,
                        output logic [15:0] rdata, output logic tout,
                        output int unsigned nrd, output int unsigned nwr,
                        output int unsigned lat, output bit ok);
    int unsigned rd0, wr0;
    int n;
    ok = 1'b1;
    @(negedge Clk);
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!cmd_ready) ok = 1'b0;
    rd0 = rd_strobes;
    wr0 = wr_strobes;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!rsp_valid && lat < 400);
    if (!rsp_valid) ok = 1'b0;
    repeat (ready_delay) @(negedge Clk);
    rdata = rsp_data;
    tout  = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
    nrd = rd_strobes - rd0;
    nwr = wr_strobes - wr0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] mask;
    logic [15:0] exp_data;
    logic        exp_to;
    int unsigned exp_rd;
    int unsigned exp_wr;
    int unsigned exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data,
                              input logic [15:0] mask, input logic [15:0] exp_data, input logic exp_to,
                              input int unsigned exp_rd, input int unsigned exp_wr, input int unsigned exp_lat);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.exp_data = exp_data;
    v.exp_to = exp_to; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_lat = exp_lat;
    return v;
  endfunction

  logic [15:0] model_mem [128];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [8];
    logic [15:0] rdata, exp_d, bp_data;
    logic        tout, exp_t, match;
    int unsigned nrd, nwr, lat, s0, e_rd, e_wr;
    bit          ok;
    logic [6:0]  idx;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] data, mask;
    int          n;

    vecs[0] = mk(OPR, 8'h44, 16'h0000, 16'h0000, 16'h0004, 1'b0, 1, 0, 5);
    vecs[1] = mk(OPW, 8'h0A, 16'h0001, 16'h0000, 16'h0001, 1'b0, 0, 1, 5);
    vecs[2] = mk(OPR, 8'h0A, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1, 0, 5);
    vecs[3] = mk(OPX, 8'h44, 16'h1234, 16'h0000, 16'h0004, 1'b0, 1, 0, 5);
    vecs[4] = mk(OPW, 8'h0B, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 0, 1, 5);
    vecs[5] = mk(OPR, 8'h0A, 16'h0000, 16'h0000, 16'hBEEF, 1'b0, 1, 0, 5);
    vecs[6] = mk(OPP, 8'h0A, 16'h12EF, 16'h00FF, 16'hBEEF, 1'b0, 1, 0, 5);
    vecs[7] = mk(OPP, 8'h44, 16'hFFFF, 16'h0000, 16'h0004, 1'b0, 1, 0, 5);

    for (int i = 0; i < 128; i++) model_mem[i] = (i == 'h22) ? 16'h0004 : 16'h0000;

    Reset = 1'b1; slave_clr = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_CSB", CSB, 1);
    check("rst_WRB", WRB, 1);
    check("rst_CA", CA, 0);
    check("rst_CD_wr", CD_wr, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    Reset = 1'b0; slave_clr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].mask, i % 3, rdata, tout, nrd, nwr, lat, ok);
      check($sformatf("vec%0d_done", i), ok, 1);
      check($sformatf("vec%0d_data", i), rdata, vecs[i].exp_data);
      check($sformatf("vec%0d_timeout", i), tout, vecs[i].exp_to);
      check($sformatf("vec%0d_rd_strobes", i), nrd, vecs[i].exp_rd);
      check($sformatf("vec%0d_wr_strobes", i), nwr, vecs[i].exp_wr);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].op == OPW) begin
        check($sformatf("vec%0d_wr_CA", i), wr_ca, vecs[i].addr);
        check($sformatf("vec%0d_wr_CD", i), wr_cd, vecs[i].data);
        model_mem[vecs[i].addr[7:1]] = vecs[i].data;
      end
    end
    check("slave_reg5", slave_mem[5], 16'hBEEF);

    // Poll with the grant bit visible from the third read onwards.
    grant_base = rd_strobes; grant_after = 2; s0 = strobe_starts;
    do_cmd(OPP, 8'h3C, 16'h0001, 16'h0001, 0, rdata, tout, nrd, nwr, lat, ok);
    check("poll_match_done", ok, 1);
    check("poll_match_bit0", rdata[0], 1);
    check("poll_match_timeout", tout, 0);
    check("poll_match_strobes", nrd, 3);
    check("poll_match_latency", lat, 17);
    check("poll_match_gap1", start_at[(s0 + 1) % 64] - start_at[s0 % 64], 6);
    check("poll_match_gap2", start_at[(s0 + 2) % 64] - start_at[(s0 + 1) % 64], 6);

    // Poll that never sees the grant.
    grant_base = rd_strobes; grant_after = 1000;
    do_cmd(OPP, 8'h3C, 16'h0001, 16'h0001, 1, rdata, tout, nrd, nwr, lat, ok);
    check("poll_to_done", ok, 1);
    check("poll_to_data", rdata, 16'h0000);
    check("poll_to_timeout", tout, 1);
    check("poll_to_strobes", nrd, POLL_MAX);
    check("poll_to_wr_strobes", nwr, 0);
    check("poll_to_latency", lat, 5 + (POLL_MAX - 1) * 6);

    // Backpressure: response held while a new command is already offered.
    @(negedge Clk);
    cmd_op = OPR; cmd_addr = 8'h44; cmd_data = '0; cmd_mask = '0; cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_op = OPW; cmd_addr = 8'h10; cmd_data = 16'h5555;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("bp_rsp_seen", rsp_valid, 1);
    bp_data = rsp_data;
    check("bp_first_data", bp_data, model_mem[7'h22]);
    s0 = rd_strobes + wr_strobes;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      check($sformatf("bp_valid_c%0d", k), rsp_valid, 1);
      check($sformatf("bp_data_c%0d", k), rsp_data, bp_data);
      check($sformatf("bp_cmd_ready_c%0d", k), cmd_ready, 0);
      check($sformatf("bp_CSB_c%0d", k), CSB, 1);
    end
    check("bp_no_bus_activity", rd_strobes + wr_strobes - s0, 0);
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
    @(negedge Clk);
    check("bp_after_hs_ready", cmd_ready, 1);
    check("bp_after_hs_rsp", rsp_valid, 0);
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    check("bp_next_accepted", busy, 1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("bp_next_data", rsp_data, 16'h5555);
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
    model_mem[7'h08] = 16'h5555;

    // Reset in the middle of a write strobe.
    @(negedge Clk);
    cmd_op = OPW; cmd_addr = 8'h20; cmd_data = 16'hA5A5; cmd_mask = '0; cmd_valid = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (CSB && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("rst_mid_in_strobe", {CSB, WRB}, 2'b00);
    #2 Reset = 1'b1;
    #1;
    check("rst_mid_CSB", CSB, 1);
    check("rst_mid_WRB", WRB, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    @(negedge Clk);
    Reset = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      if (rsp_valid || !CSB) n++;
    end
    check("rst_mid_quiet", n, 0);
    do_cmd(OPR, 8'h20, 16'h0000, 16'h0000, 0, rdata, tout, nrd, nwr, lat, ok);
    check("rst_mid_read_done", ok, 1);
    check("rst_mid_read_data", rdata, model_mem[7'h10]);
    check("rst_mid_read_timeout", tout, 0);

    // Random commands against the memory model.
    for (int it = 0; it < 40; it++) begin
      do idx = 7'($urandom_range(0, 127)); while (idx == 7'h1E);
      op   = 2'($urandom_range(0, 3));
      addr = {idx, 1'($urandom_range(0, 1))};
      mask = 16'($urandom);
      data = 16'($urandom);
      if (op == OPP && $urandom_range(0, 1) == 1) data = model_mem[idx] ^ (~mask & 16'($urandom));
      if (op == OPW) begin
        exp_d = data; exp_t = 1'b0; e_rd = 0; e_wr = 1;
      end else if (op == OPP) begin
        match = (((model_mem[idx] ^ data) & mask) == 16'h0000);
        exp_d = model_mem[idx]; exp_t = !match; e_rd = match ? 1 : POLL_MAX; e_wr = 0;
      end else begin
        exp_d = model_mem[idx]; exp_t = 1'b0; e_rd = 1; e_wr = 0;
      end
      do_cmd(op, addr, data, mask, $urandom_range(0, 3), rdata, tout, nrd, nwr, lat, ok);
      check($sformatf("rnd%0d_data", it), rdata, exp_d);
      check($sformatf("rnd%0d_timeout", it), {ok, tout}, {1'b1, exp_t});
      check($sformatf("rnd%0d_strobes", it), {nrd[15:0], nwr[15:0]}, {e_rd[15:0], e_wr[15:0]});
      if (op == OPW) model_mem[idx] = data;
    end

    check("bus_stable_under_CSB", bus_glitch, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
